// File: rtl/pattern_frame_tx_if.sv
// Word handshake between an upstream producer
// and the serial frame transmitter.
interface pattern_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/pattern_frame_tx.sv
// Bit-serial framer: sync preamble, then an
// MSB-first payload, then forced-0 gap bits.
module pattern_frame_tx #(
  parameter int             DATA_W   = 8,
  parameter int             PRE_W    = 6,
  parameter logic [PRE_W-1:0] PREAMBLE = 6'b110101,
  parameter int             GAP      = 1
) (
  input  logic clk,
  input  logic rest,
  pattern_frame_tx_if.slave bus,
  output logic out,
  output logic busy,
  output logic frame_start,
  output logic frame_done
);

  localparam int MX0 = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int MX1 = (MX0 > GAP) ? MX0 : GAP;
  localparam int MX  = (MX1 > 2) ? MX1 : 2;
  localparam int CW  = $clog2(MX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_GAP
  } state_t;

  state_t            state, nstate;
  logic [CW-1:0]     cnt, ncnt;
  logic [DATA_W-1:0] shift, nshift;
  logic              accept;
  logic              out_d, start_d, done_d;

  assign bus.data_ready = (state == S_IDLE) & ~rest;
  assign accept = bus.data_valid & bus.data_ready;

  always_comb begin
    nstate = state;
    ncnt   = cnt;
    nshift = shift;
    case (state)
      S_IDLE: begin
        if (accept) begin
          nstate = S_PRE;
          ncnt   = CW'(PRE_W - 1);
          nshift = bus.data_in;
        end
      end
      S_PRE: begin
        if (cnt == '0) begin
          nstate = S_DATA;
          ncnt   = CW'(DATA_W - 1);
        end else begin
          ncnt = cnt - 1'b1;
        end
      end
      S_DATA: begin
        nshift = shift << 1;
        if (cnt == '0) begin
          if (GAP > 0) begin
            nstate = S_GAP;
            ncnt   = CW'((GAP > 0) ? GAP - 1 : 0);
          end else begin
            nstate = S_IDLE;
            ncnt   = '0;
          end
        end else begin
          ncnt = cnt - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt == '0) begin
          nstate = S_IDLE;
          ncnt   = '0;
        end else begin
          ncnt = cnt - 1'b1;
        end
      end
      default: begin
        nstate = S_IDLE;
        ncnt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land in a register
  always_comb begin
    out_d = 1'b0;
    case (nstate)
      S_PRE:   out_d = PREAMBLE[ncnt];
      S_DATA:  out_d = nshift[DATA_W-1];
      default: out_d = 1'b0;
    endcase
    start_d = (state == S_IDLE) && (nstate == S_PRE);
    done_d  = (nstate == S_DATA) && (ncnt == '0);
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state       <= S_IDLE;
      cnt         <= '0;
      shift       <= '0;
      out         <= 1'b0;
      busy        <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= nstate;
      cnt         <= ncnt;
      shift       <= nshift;
      out         <= out_d;
      busy        <= (nstate != S_IDLE);
      frame_start <= start_d;
      frame_done  <= done_d;
    end
  end

endmodule

// File: tb/tb_pattern_frame_tx.sv
// Directed bench for pattern_frame_tx: default
// build plus a DATA_W=4, GAP=0 build.
module tb_pattern_frame_tx;

  logic clk;
  logic rest;
  logic out, busy, frame_start, frame_done;
  logic out2, busy2, fs2, fd2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hits = 0;
  logic [5:0] win = '0;

  pattern_frame_tx_if #(.DATA_W(8)) bus ();
  pattern_frame_tx_if #(.DATA_W(4)) bus2 ();

  pattern_frame_tx dut (
    .clk         (clk),
    .rest        (rest),
    .bus         (bus.slave),
    .out         (out),
    .busy        (busy),
    .frame_start (frame_start),
    .frame_done  (frame_done)
  );

  pattern_frame_tx #(
    .DATA_W (4),
    .GAP    (0)
  ) dut2 (
    .clk         (clk),
    .rest        (rest),
    .bus         (bus2.slave),
    .out         (out2),
    .busy        (busy2),
    .frame_start (fs2),
    .frame_done  (fd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference sync detector fed from the line
  always @(posedge clk) begin
    win <= {win[4:0], out};
    if ({win[4:0], out} == 6'b110101)
      hits <= hits + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_accept(input string tag,
                             output int c);
    logic rdy;
    logic got;
    got = 1'b0;
    c = -1;
    for (int n = 0; n < 40 && !got; n++) begin
      rdy = bus.data_ready & bus.data_valid;
      @(posedge clk);
      #1;
      if (rdy) begin
        got = 1'b1;
        c = cyc;
      end
    end
    if (!got) chk({tag, "_timeout"}, 0, 1);
  endtask

  // Called at #1 after the accept edge; n samples
  task automatic frame_chk(input string tag,
                           input logic [7:0] d,
                           input int n);
    logic [13:0] s;
    s = {6'b110101, d};
    for (int i = 1; i <= n; i++) begin
      if (i > 1) begin
        @(posedge clk);
        #1;
      end
      if (i <= 14) begin
        chk($sformatf("%s_out%0d", tag, i),
            out, s[14-i]);
        chk($sformatf("%s_fs%0d", tag, i),
            frame_start, (i == 1));
        chk($sformatf("%s_fd%0d", tag, i),
            frame_done, (i == 14));
        chk($sformatf("%s_busy%0d", tag, i),
            busy, 1);
        chk($sformatf("%s_rdy%0d", tag, i),
            bus.data_ready, 0);
      end else if (i == 15) begin
        chk({tag, "_gap_out"}, out, 0);
        chk({tag, "_gap_busy"}, busy, 1);
        chk({tag, "_gap_fd"}, frame_done, 0);
        chk({tag, "_gap_rdy"}, bus.data_ready, 0);
      end else begin
        chk({tag, "_idle_out"}, out, 0);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_rdy"}, bus.data_ready, 1);
      end
    end
  endtask

  initial begin
    int c1, c2, h0, crel;
    logic [9:0] s2;
    logic got2;

    rest = 1'b1;
    bus.data_valid = 1'b1;
    bus.data_in = 8'hA5;
    bus2.data_valid = 1'b0;
    bus2.data_in = 4'h0;

    // Reset held with valid asserted
    #3;
    chk("rst_out", out, 0);
    chk("rst_rdy", bus.data_ready, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_out", out, 0);
    chk("rst_hold_busy", busy, 0);
    chk("rst_hold_fs", frame_start, 0);
    rest = 1'b0;
    crel = cyc;
    #1;
    chk("rel_rdy", bus.data_ready, 1);

    // Single frame A5
    wait_accept("a5", c1);
    chk("a5_first_edge", c1 - crel, 1);
    bus.data_valid = 1'b0;
    frame_chk("a5", 8'hA5, 16);

    // Back-to-back FF then 00, valid held
    h0 = hits;
    bus.data_valid = 1'b1;
    bus.data_in = 8'hFF;
    wait_accept("ff", c1);
    bus.data_in = 8'h00;
    frame_chk("ff", 8'hFF, 16);
    wait_accept("z0", c2);
    chk("b2b_spacing", c2 - c1, 16);
    bus.data_valid = 1'b0;
    frame_chk("z0", 8'h00, 16);
    chk("loop_hits", hits - h0, 2);

    // Data changes during PRE are not seen
    bus.data_valid = 1'b1;
    bus.data_in = 8'h3C;
    wait_accept("s3c", c1);
    bus.data_in = 8'hC3;
    frame_chk("s3c", 8'h3C, 16);
    wait_accept("sc3", c2);
    chk("stall_spacing", c2 - c1, 16);
    bus.data_valid = 1'b0;
    frame_chk("sc3", 8'hC3, 16);

    // Reset during payload bit 3
    bus.data_valid = 1'b1;
    bus.data_in = 8'hA5;
    wait_accept("ra5", c1);
    bus.data_valid = 1'b0;
    frame_chk("ra5", 8'hA5, 10);
    #3;
    rest = 1'b1;
    #1;
    chk("mid_rst_out", out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_fd", frame_done, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("mid_rst_nofd%0d", i),
          frame_done, 0);
    end
    rest = 1'b0;
    bus.data_valid = 1'b1;
    bus.data_in = 8'h5A;
    wait_accept("p5a", c1);
    bus.data_valid = 1'b0;
    frame_chk("p5a", 8'h5A, 16);

    // Narrow payload, no gap
    bus2.data_valid = 1'b1;
    bus2.data_in = 4'b1001;
    got2 = 1'b0;
    for (int n = 0; n < 40 && !got2; n++) begin
      got2 = bus2.data_ready;
      @(posedge clk);
      #1;
    end
    if (!got2) chk("n4_timeout", 0, 1);
    bus2.data_valid = 1'b0;
    s2 = {6'b110101, 4'b1001};
    for (int i = 1; i <= 11; i++) begin
      if (i > 1) begin
        @(posedge clk);
        #1;
      end
      if (i <= 10) begin
        chk($sformatf("n4_out%0d", i), out2, s2[10-i]);
        chk($sformatf("n4_fs%0d", i), fs2, (i == 1));
        chk($sformatf("n4_fd%0d", i), fd2, (i == 10));
        chk($sformatf("n4_rdy%0d", i),
            bus2.data_ready, 0);
      end else begin
        chk("n4_idle_out", out2, 0);
        chk("n4_idle_busy", busy2, 0);
        chk("n4_idle_rdy", bus2.data_ready, 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
